fu_issue_ctrl: RTL and testbench

//  Issue side of the functional-unit EN/finish interface. It sits between the issue stage and one

---
 rtl/fu_issue_if.sv | 37 +++
 rtl/fu_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fu_issue_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_issue_if.sv
// Issue-side bundle for one fixed-latency FU: request queue input, FU EN/finish
// handshake and writeback valid/ready, plus status flags.
interface fu_issue_if #(
    parameter int unsigned TAG_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_A;
    logic [31:0]      req_B;
    logic [TAG_W-1:0] req_tag;

    logic             fu_EN;
    logic [31:0]      fu_A;
    logic [31:0]      fu_B;
    logic [31:0]      fu_res;
    logic             fu_finish;

    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_res;
    logic [TAG_W-1:0] wb_tag;

    logic             busy;
    logic             timeout_err;

    // Environment side: issue stage, FU and writeback.
    modport master (
        output req_valid, req_A, req_B, req_tag, fu_res, fu_finish, wb_ready,
        input  req_ready, fu_EN, fu_A, fu_B, wb_valid, wb_res, wb_tag, busy, timeout_err
    );

    // Controller side.
    modport slave (
        input  req_valid, req_A, req_B, req_tag, fu_res, fu_finish, wb_ready,
        output req_ready, fu_EN, fu_A, fu_B, wb_valid, wb_res, wb_tag, busy, timeout_err
    );
endinterface

// File: rtl/fu_issue_ctrl.sv
// Issue controller for a single fixed-latency FU: queues ops, pulses EN with held
// operands, captures the result on finish and offers it to writeback; watchdog on WAIT.
module fu_issue_ctrl #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic     clk,
    input  logic     rst,
    fu_issue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = 2 * DW + TAG_W;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [DW-1:0]    op_a_q, op_a_d;
    logic [DW-1:0]    op_b_q, op_b_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;
    logic [DW-1:0]    wb_res_q, wb_res_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             wb_valid_q, wb_valid_d;
    logic             fu_en_q, fu_en_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;

    logic             empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = bus.req_valid && req_ready_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // FSM: next state, pop decision, op/wb buffer updates and watchdog.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_tag_d      = op_tag_q;
        wb_res_d      = wb_res_q;
        wb_tag_d      = wb_tag_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A finish arriving on the last watchdog cycle still completes the op.
                if (bus.fu_finish) begin
                    wb_res_d = bus.fu_res;
                    wb_tag_d = op_tag_q;
                    state_d  = S_WB;
                end else if (wdog_q == WW'(TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            {op_a_d, op_b_d, op_tag_d} = head;
        end
        fu_en_d    = (state_d == S_ISSUE);
        wb_valid_d = (state_d == S_WB);
    end

    // Request FIFO: write side, read pointer and registered ready.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {bus.req_A, bus.req_B, bus.req_tag};
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        rd_ptr_d    = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        req_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
    end

    always_comb begin
        busy_d = (state_d != S_IDLE) || (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_q         <= '{default: '0};
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_tag_q      <= '0;
            wb_res_q      <= '0;
            wb_tag_q      <= '0;
            wdog_q        <= '0;
            wb_valid_q    <= 1'b0;
            fu_en_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_tag_q      <= op_tag_d;
            wb_res_q      <= wb_res_d;
            wb_tag_q      <= wb_tag_d;
            wdog_q        <= wdog_d;
            wb_valid_q    <= wb_valid_d;
            fu_en_q       <= fu_en_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.fu_EN       = fu_en_q;
    assign bus.fu_A        = op_a_q;
    assign bus.fu_B        = op_b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_res      = wb_res_q;
    assign bus.wb_tag      = wb_tag_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_fu_issue_ctrl.sv
// Bench for fu_issue_ctrl: behavioural fixed-latency FU plus a result scoreboard
// filled at request push and drained at writeback transfer.
module tb_fu_issue_ctrl;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned TIMEOUT = 15;

    logic clk;
    logic rst;

    fu_issue_if #(.TAG_W(TAG_W)) bus ();

    fu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int en_cyc   = 0;
    int fin_cyc  = 0;
    int push_cyc = 0;
    int fu_cnt   = 0;
    int fu_lat   = 0;
    int n_done   = 0;
    bit saw_wb   = 0;
    logic [31:0] fu_a_l, fu_b_l;
    logic [32+TAG_W-1:0] sb_q [$];

    // One clock: record push/transfer before the edge, then run the FU model after it.
    task automatic cycle();
        logic [31:0]         prod;
        logic [32+TAG_W-1:0] exp_v;
        bit                  pushed;
        pushed = 0;
        if (!rst && bus.req_valid && bus.req_ready) begin
            prod = bus.req_A * bus.req_B;
            sb_q.push_back({prod, bus.req_tag});
            pushed = 1;
        end
        if (bus.wb_valid && bus.wb_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL wb_unexpected: got res=%0d tag=%0d with no op outstanding",
                         bus.wb_res, bus.wb_tag);
            end else begin
                exp_v = sb_q.pop_front();
                if ({bus.wb_res, bus.wb_tag} !== exp_v)
                    $display("FAIL wb_data: got res=%0d tag=%0d want res=%0d tag=%0d",
                             bus.wb_res, bus.wb_tag, exp_v[32+TAG_W-1:TAG_W], exp_v[TAG_W-1:0]);
                else
                    n_pass++;
            end
            n_done++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pushed) push_cyc = cyc;
        bus.fu_finish = 1'b0;
        if (fu_cnt > 0) begin
            fu_cnt--;
            if (fu_cnt == 0) begin
                n_checks++;
                if (bus.fu_A !== fu_a_l || bus.fu_B !== fu_b_l)
                    $display("FAIL fu_operand_hold: got A=%0d B=%0d want A=%0d B=%0d",
                             bus.fu_A, bus.fu_B, fu_a_l, fu_b_l);
                else
                    n_pass++;
                bus.fu_finish = 1'b1;
                bus.fu_res    = fu_a_l * fu_b_l;
                fin_cyc       = cyc;
            end
        end
        if (bus.fu_EN) begin
            en_cnt++;
            en_cyc = cyc;
            fu_a_l = bus.fu_A;
            fu_b_l = bus.fu_B;
            fu_cnt = fu_lat;
        end
        if (bus.wb_valid) saw_wb = 1;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        bit done;
        done          = 0;
        bus.req_A     = a;
        bus.req_B     = b;
        bus.req_tag   = t;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            done = bus.req_ready;
            cycle();
            if (done) break;
        end
        bus.req_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL push_stuck: req_ready stayed 0 for tag %0d", t);
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !bus.busy) begin
                ok = 1;
                break;
            end
            cycle();
        end
        n_checks++;
        if (!ok) $display("FAIL drain: %0d ops outstanding, busy=%0b want 0 and 0", sb_q.size(), bus.busy);
        else n_pass++;
    endtask

    task automatic wait_en(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fu_EN) begin
                ok = 1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready);
        else n_pass++;
        n_checks++;
        if (bus.fu_EN !== 1'b0) $display("FAIL reset_fu_EN: got %0b want 0", bus.fu_EN);
        else n_pass++;
        n_checks++;
        if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %0b want 0", bus.wb_valid);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %0b want 0", bus.timeout_err);
        else n_pass++;
        n_checks++;
        if ({bus.fu_A, bus.fu_B, bus.wb_res, bus.wb_tag} !== '0)
            $display("FAIL reset_data: got fu_A=%0d fu_B=%0d wb_res=%0d wb_tag=%0d want all 0",
                     bus.fu_A, bus.fu_B, bus.wb_res, bus.wb_tag);
        else n_pass++;
    endtask

    task automatic test_single();
        int  e0, d0;
        bit  ok;
        fu_lat       = 6;
        bus.wb_ready = 1'b1;
        e0           = en_cnt;
        d0           = n_done;
        push_op(32'd3, 32'd5, 3'd2);
        wait_en(ok);
        n_checks++;
        if (!ok || cyc != push_cyc + 1)
            $display("FAIL single_en_latency: got EN at cycle %0d (seen=%0b) want %0d", cyc, ok, push_cyc + 1);
        else n_pass++;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wb_valid) begin
                ok = 1;
                break;
            end
            cycle();
        end
        n_checks++;
        if (!ok || cyc != fin_cyc + 1 || fin_cyc != en_cyc + 6)
            $display("FAIL single_wb_latency: got wb_valid at cycle %0d want %0d", cyc, en_cyc + 7);
        else n_pass++;
        n_checks++;
        if (bus.wb_res !== 32'd15 || bus.wb_tag !== 3'd2)
            $display("FAIL single_wb_data: got res=%0d tag=%0d want res=15 tag=2", bus.wb_res, bus.wb_tag);
        else n_pass++;
        wait_drain();
        n_checks++;
        if (en_cnt - e0 != 1) $display("FAIL single_en_count: got %0d want 1", en_cnt - e0);
        else n_pass++;
        n_checks++;
        if (n_done - d0 != 1) $display("FAIL single_done_count: got %0d want 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e0, d0, c0;
        fu_lat       = 3;
        bus.wb_ready = 1'b1;
        e0           = en_cnt;
        d0           = n_done;
        push_op(32'd10, 32'd11, 3'd1);
        push_op(32'd12, 32'd13, 3'd3);
        push_op(32'd14, 32'd15, 3'd5);
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL b2b_full_ready: got %0b want 0", bus.req_ready);
        else n_pass++;
        c0 = cyc;
        push_op(32'd16, 32'd17, 3'd7);
        n_checks++;
        if (cyc - c0 < 2) $display("FAIL b2b_stall: got accept after %0d cycles want >=2", cyc - c0);
        else n_pass++;
        wait_drain();
        n_checks++;
        if (n_done - d0 != 4) $display("FAIL b2b_done_count: got %0d want 4", n_done - d0);
        else n_pass++;
        n_checks++;
        if (en_cnt - e0 != 4) $display("FAIL b2b_en_count: got %0d want 4", en_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_wb_stall();
        int e0;
        bit ok, stable;
        fu_lat       = 2;
        bus.wb_ready = 1'b0;
        push_op(32'd6, 32'd7, 3'd4);
        push_op(32'd8, 32'd9, 3'd6);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wb_valid) begin
                ok = 1;
                break;
            end
            cycle();
        end
        n_checks++;
        if (!ok) $display("FAIL stall_wb_valid: got 0 want 1");
        else n_pass++;
        e0     = en_cnt;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.wb_valid !== 1'b1 || bus.wb_res !== 32'd42 || bus.wb_tag !== 3'd4) stable = 0;
        end
        n_checks++;
        if (!stable)
            $display("FAIL stall_hold: got valid=%0b res=%0d tag=%0d want valid=1 res=42 tag=4",
                     bus.wb_valid, bus.wb_res, bus.wb_tag);
        else n_pass++;
        n_checks++;
        if (en_cnt != e0) $display("FAIL stall_no_en: got %0d EN pulses want 0", en_cnt - e0);
        else n_pass++;
        bus.wb_ready = 1'b1;
        cycle();
        n_checks++;
        if (bus.fu_EN !== 1'b1 || bus.wb_valid !== 1'b0)
            $display("FAIL stall_release: got fu_EN=%0b wb_valid=%0b want 1 0", bus.fu_EN, bus.wb_valid);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_finish_edge();
        int e0, d0;
        e0            = en_cnt;
        d0            = n_done;
        bus.fu_res    = 32'hDEAD_BEEF;
        bus.fu_finish = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 || en_cnt != e0)
            $display("FAIL stray_finish: got wb_valid=%0b busy=%0b err=%0b en=%0d want 0 0 0 0",
                     bus.wb_valid, bus.busy, bus.timeout_err, en_cnt - e0);
        else n_pass++;
        fu_lat = TIMEOUT + 1;
        push_op(32'd20, 32'd21, 3'd3);
        wait_drain();
        n_checks++;
        if (bus.timeout_err !== 1'b0) $display("FAIL edge_finish_err: got %0b want 0", bus.timeout_err);
        else n_pass++;
        n_checks++;
        if (n_done - d0 != 1) $display("FAIL edge_finish_done: got %0d want 1", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int  e0, t_en;
        bit  ok;
        fu_lat = 0;
        e0     = en_cnt;
        push_op(32'd30, 32'd31, 3'd2);
        wait_en(ok);
        t_en = en_cyc;
        ok   = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.timeout_err) begin
                ok = 1;
                break;
            end
            cycle();
        end
        n_checks++;
        if (!ok || cyc != t_en + int'(TIMEOUT) + 2)
            $display("FAIL timeout_cycle: got err at cycle %0d (seen=%0b) want %0d",
                     cyc, ok, t_en + int'(TIMEOUT) + 2);
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0)
            $display("FAIL timeout_idle: got busy=%0b wb_valid=%0b want 0 0", bus.busy, bus.wb_valid);
        else n_pass++;
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        fu_lat = 4;
        push_op(32'd2, 32'd3, 3'd1);
        wait_drain();
        n_checks++;
        if (bus.timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %0b want 1", bus.timeout_err);
        else n_pass++;
        n_checks++;
        if (en_cnt - e0 != 2) $display("FAIL timeout_next_issue: got %0d EN want 2", en_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int e0;
        fu_lat       = 0;
        bus.wb_ready = 1'b1;
        push_op(32'd1, 32'd1, 3'd1);
        push_op(32'd2, 32'd2, 3'd2);
        push_op(32'd3, 32'd3, 3'd3);
        cycle();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0)
            $display("FAIL rstmid_pre: got busy=%0b req_ready=%0b want 1 0", bus.busy, bus.req_ready);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.fu_EN !== 1'b0 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0)
            $display("FAIL rstmid_async_ctrl: got ready=%0b EN=%0b busy=%0b wb_valid=%0b want 1 0 0 0",
                     bus.req_ready, bus.fu_EN, bus.busy, bus.wb_valid);
        else n_pass++;
        n_checks++;
        if (bus.timeout_err !== 1'b0 || bus.fu_A !== 32'd0 || bus.fu_B !== 32'd0)
            $display("FAIL rstmid_async_data: got err=%0b fu_A=%0d fu_B=%0d want 0 0 0",
                     bus.timeout_err, bus.fu_A, bus.fu_B);
        else n_pass++;
        sb_q.delete();
        fu_cnt = 0;
        saw_wb = 0;
        cycle();
        cycle();
        rst    = 1'b0;
        fu_lat = 3;
        e0     = en_cnt;
        for (int i = 0; i < 25; i++) cycle();
        n_checks++;
        if (saw_wb || en_cnt != e0 || bus.busy !== 1'b0)
            $display("FAIL rstmid_after: got saw_wb=%0b EN=%0d busy=%0b want 0 0 0",
                     saw_wb, en_cnt - e0, bus.busy);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_A     = '0;
        bus.req_B     = '0;
        bus.req_tag   = '0;
        bus.fu_res    = '0;
        bus.fu_finish = 1'b0;
        bus.wb_ready  = 1'b1;
        cycle();
        cycle();
        test_reset();
        rst = 1'b0;
        cycle();
        test_single();
        test_back_to_back();
        test_wb_stall();
        test_finish_edge();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
